// File: rtl/half_add_pkg.sv
// Shared types and widths for the half_add slice.
// Each lane result is packed as {carry, s}, so an array of lanes matches the flat sum bus.
package half_add_pkg;

  localparam int SUM_W = 2;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic carry;
    logic s;
  } lane_sum_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/half_add_bit.sv
// Combinational single-lane half adder cell: s = a ^ b, c = a & b.
module half_add_bit (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/half_add.sv
// Registered LANES-wide half adder with a 1-cycle valid strobe.
// Define HALFADD_STATS_EN to add saturating carry_cnt/op_cnt statistics outputs.
module half_add
  import half_add_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [LANES-1:0]       a,
  input  logic [LANES-1:0]       b,
  output logic                   out_valid,
  output logic [LANES-1:0]       cout,
  output logic [SUM_W*LANES-1:0] sum
`ifdef HALFADD_STATS_EN
  ,
  output logic [CNT_W-1:0]       carry_cnt,
  output logic [CNT_W-1:0]       op_cnt
`endif
);

  lane_sum_t [LANES-1:0]   lane_res;
  logic [SUM_W*LANES-1:0]  sum_d, sum_q;
  logic [LANES-1:0]        cout_d, cout_q;
  logic                    valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    half_add_bit u_bit (
      .a_i (a[gi]),
      .b_i (b[gi]),
      .s_o (lane_res[gi].s),
      .c_o (lane_res[gi].carry)
    );
    assign cout_d[gi] = lane_res[gi].carry;
  end

  assign sum_d = lane_res;

  // Data registers only load on accepted inputs, so X on a/b while idle never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef HALFADD_STATS_EN
  logic [CNT_W-1:0] carry_cnt_q, op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else if (in_valid) begin
      op_cnt_q <= sat_inc(op_cnt_q);
      if (|cout_d) begin
        carry_cnt_q <= sat_inc(carry_cnt_q);
      end
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign op_cnt    = op_cnt_q;
`endif

endmodule

// File: tb/tb_half_add.sv
// Scoreboard bench for half_add (LANES=4): stimulus pushes expected results, a negedge monitor pops them.
// Define HALFADD_STATS_EN to also exercise the statistics counters.
module tb_half_add;

  localparam int LANES = 4;

  typedef struct {
    logic [2*LANES-1:0] sum;
    logic [LANES-1:0]   cout;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [LANES-1:0]   a;
  logic [LANES-1:0]   b;
  logic               out_valid;
  logic [LANES-1:0]   cout;
  logic [2*LANES-1:0] sum;
`ifdef HALFADD_STATS_EN
  logic [15:0]        carry_cnt;
  logic [15:0]        op_cnt;
`endif

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  half_add #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .cout      (cout),
    .sum       (sum)
`ifdef HALFADD_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .op_cnt    (op_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every valid result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFails++;
        $display("[TB] FAIL unexpected_valid: out_valid=1 with no expected result (sum=%b cout=%b)", sum, cout);
      end else begin
        e = expQ.pop_front();
        if (sum !== e.sum || cout !== e.cout) begin
          nFails++;
          $display("[TB] FAIL result: got sum=%b cout=%b, expected sum=%b cout=%b", sum, cout, e.sum, e.cout);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [LANES-1:0] av, input logic [LANES-1:0] bv,
                               input logic [2*LANES-1:0] es, input logic [LANES-1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    e.sum    = es;
    e.cout   = ec;
    expQ.push_back(e);
  endtask

  task automatic goIdle(input logic [LANES-1:0] av, input logic [LANES-1:0] bv);
    @(posedge clk);
    #1;
    a        = av;
    b        = bv;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic expValid,
                             input logic [2*LANES-1:0] expSum, input logic [LANES-1:0] expCout);
    nChecks++;
    if (out_valid !== expValid || sum !== expSum || cout !== expCout) begin
      nFails++;
      $display("[TB] FAIL %s: got valid=%b sum=%b cout=%b, expected valid=%b sum=%b cout=%b",
               name, out_valid, sum, cout, expValid, expSum, expCout);
    end
  endtask

`ifdef HALFADD_STATS_EN
  task automatic checkStats(input string name, input logic [15:0] expOp, input logic [15:0] expCarry);
    nChecks++;
    if (op_cnt !== expOp || carry_cnt !== expCarry) begin
      nFails++;
      $display("[TB] FAIL %s: got op_cnt=%h carry_cnt=%h, expected op_cnt=%h carry_cnt=%h",
               name, op_cnt, carry_cnt, expOp, expCarry);
    end
  endtask
`endif

  task automatic drain();
    int waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = '1;
    b        = '1;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_hold", 1'b0, '0, '0);
`ifdef HALFADD_STATS_EN
      checkStats("reset_stats", 16'd0, 16'd0);
`endif
    end
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #2 rst_n = 1'b1;

    // Truth table replicated across all lanes.
    applyStimulus(4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000);
    applyStimulus(4'b0000, 4'b1111, 8'b01_01_01_01, 4'b0000);
    applyStimulus(4'b1111, 4'b0000, 8'b01_01_01_01, 4'b0000);
    applyStimulus(4'b1111, 4'b1111, 8'b10_10_10_10, 4'b1111);

    // Hold: five idle cycles must keep the last result with out_valid low.
    goIdle(4'b0000, 4'b0000);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold", 1'b0, 8'b10_10_10_10, 4'b1111);
    end
    drain();
`ifdef HALFADD_STATS_EN
    checkStats("stats_truth_table", 16'd4, 16'd1);
`endif

    // Independent lanes with mixed patterns.
    applyStimulus(4'b1100, 4'b1010, 8'b10_01_01_00, 4'b1000);
    applyStimulus(4'b0110, 4'b0011, 8'b00_01_10_01, 4'b0010);
    applyStimulus(4'b1111, 4'b0000, 8'b01_01_01_01, 4'b0000);
    goIdle('x, 'x);
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_x_inputs", 1'b0, 8'b01_01_01_01, 4'b0000);
    drain();
`ifdef HALFADD_STATS_EN
    checkStats("stats_multilane", 16'd7, 16'd3);
`endif

    // Asynchronous reset between edges right after a result appears.
    applyStimulus(4'b1111, 4'b1111, 8'b10_10_10_10, 4'b1111);
    goIdle(4'b0000, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, '0, '0);
`ifdef HALFADD_STATS_EN
    checkStats("async_reset_stats", 16'd0, 16'd0);
`endif
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 1'b0, '0, '0);
    end
    drain();

`ifdef HALFADD_STATS_EN
    // Push both counters well past their saturation point.
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(4'b1111, 4'b1111, 8'b10_10_10_10, 4'b1111);
    end
    applyStimulus(4'b0000, 4'b0000, 8'b00_00_00_00, 4'b0000);
    goIdle(4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    drain();
    checkStats("stats_saturate", 16'hFFFF, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/half_add.md
Name: half_add

Overview:
- Registered 1-bit half adder, replicated across LANES independent lanes.
- Each lane forms the 2-bit arithmetic result of a+b and a separate carry flag.
- Results are registered with a 1-cycle latency and a valid strobe.
- Leaf arithmetic block used by wider adder and counter datapaths.

Parameters:
- LANES, 1, number of independent half-adder lanes (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are valid this cycle.
- a  input  LANES  addend bit per lane.
- b  input  LANES  addend bit per lane.
- out_valid  output  1  sum/cout hold a new result.
- cout  output  LANES  per-lane carry (a AND b).
- sum  output  2*LANES  per-lane 2-bit result; lane i occupies sum[2i+1:2i] = {a[i]&b[i], a[i]^b[i]}.

Behaviour:
- Reset:
  - rst_n low immediately clears out_valid, cout and sum to 0, regardless of clk.
  - Outputs stay 0 while rst_n is low.
  - Release is synchronous-safe: the first capture happens on the first rising clk edge after rst_n goes high.
- Capture, per lane i, on a rising clk edge with in_valid=1:
  - sum[2i] <= a[i] XOR b[i]
  - sum[2i+1] <= a[i] AND b[i]
  - cout[i] <= a[i] AND b[i]
  - out_valid <= 1
- Hold: on a rising edge with in_valid=0, out_valid <= 0 and sum/cout hold their last values (no clearing).
- Latency: exactly 1 cycle from in_valid to out_valid. Throughput is one result per cycle, with no backpressure.
- Arithmetic: sum lane value equals integer a[i]+b[i] in 0..2. cout[i] always equals sum[2i+1].
- Lanes are fully independent, with no carry propagation between lanes.
- Reset mid-operation: a result in flight is discarded, and out_valid is 0 after reset deasserts until the next accepted input.
- X on a/b while in_valid=0 must not disturb the outputs.

Optional Feature:
- Macro: HALFADD_STATS_EN.
- With the macro defined, two extra outputs are added, both cleared by rst_n and updated only on accepted inputs (in_valid=1):
  - carry_cnt (16 bits): increments by one for each accepted cycle in which any lane produces a carry. Saturates at 16'hFFFF.
  - op_cnt (16 bits): counts accepted inputs. Saturates at 16'hFFFF.
- Without the macro, these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- Shared package half_add_pkg holds:
  - localparam SUM_W = 2 (per-lane result width).
  - localparam CNT_W = 16 (stats counter width).
  - typedef lane_sum_t as a 2-bit packed struct {carry, s}.
- Sub-module half_add_bit: combinational single-lane cell (a, b -> s, c), instantiated LANES times in a generate loop. The top level owns all registers.

Test Plan:
- Reset: hold rst_n=0, toggle clk with a=1, b=1, in_valid=1 -> out_valid=0, sum=2'b00, cout=0 throughout. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Truth table (LANES=1), one input per cycle: (a,b)=00,01,10,11 with in_valid=1, each result checked one cycle later:
  - 00 -> sum=00, cout=0
  - 01 -> sum=01, cout=0
  - 10 -> sum=01, cout=0
  - 11 -> sum=10, cout=1
  - out_valid=1 on each result cycle.
- Hold: after a=1, b=1 is accepted, drive in_valid=0 with a=0, b=0 for 5 cycles -> out_valid=0, sum stays 10, cout stays 1.
- Multi-lane (LANES=4): a=4'b1100, b=4'b1010 -> cout=4'b1000, sum=8'b10_01_01_00, lanes independent.
- Reset mid-stream: accept a=1, b=1, then pulse rst_n low before the next edge -> out_valid=0, sum=00. After release with in_valid=0 -> outputs remain 0.
- With HALFADD_STATS_EN (LANES=1): drive the four truth-table inputs with in_valid=1 -> op_cnt=4, carry_cnt=1. Force 70000 accepted 11 inputs -> both counters saturate at 16'hFFFF.
